led_breathe_seq: RTL
====================

Name: led_breathe_seq

Overview:
- Downstream LED output stage for the board's free-running 32-bit heartbeat counter.
- Consumes a single-cycle tick strobe derived from that counter. Generates a PWM "breathing" brightness ramp on the five board LEDs.
- Offers selectable patterns: off, breathe-all, chase, full-on.
- All outputs are registered; the block replaces direct wiring of counter bits to LED pins.

Parameters:
- PWM_BITS, 8: width of the PWM counter and duty register. MAX = 2^PWM_BITS-1.
- STEP_TICKS, 4: tick strobes per brightness step. Must be >= 1.
- NUM_LEDS, 5: number of LED outputs.

Ports:
- hwclk  in  1  system clock; the only clock.
- rst  in  1  reset; synchronous, active-high.
- tick  in  1  step strobe, counted once per hwclk cycle it is high.
- mode  in  2  0=OFF, 1=BREATHE, 2=CHASE, 3=FULL.
- led  out  NUM_LEDS  LED drive, registered.
- duty  out  PWM_BITS  current brightness, registered.
- dir_down  out  1  0=ramping up, 1=ramping down.
- pos  out  3  chase position, 0..NUM_LEDS-1.

Behaviour:
- Clocking and reset:
  - One clock, hwclk. Reset is synchronous and active-high. rst overrides every other input on the same edge.
  - Reset values: led=0, duty=0, dir_down=0, pos=0, pwm_cnt=0, step_cnt=0.
  - Reset mid-ramp: all state returns to reset values on the next edge; a tick in the same cycle is ignored.
- pwm_cnt (internal, PWM_BITS wide): increments every cycle and wraps MAX->0. It runs in every mode, including OFF.
- Step generation:
  - step_cnt counts tick cycles.
  - When tick=1 and step_cnt==STEP_TICKS-1, a step event fires and step_cnt returns to 0. Otherwise a tick increments step_cnt.
  - In mode OFF, step_cnt, duty, dir_down and pos are frozen.
- Ramp FSM, two states (UP: dir_down=0, DOWN: dir_down=1), acting only on a step event:
  - UP, duty<MAX: duty+1.
  - UP, duty==MAX: duty<=MAX-1, go to DOWN.
  - DOWN, duty>0: duty-1.
  - DOWN, duty==0: duty<=1, go to UP, pos advances (NUM_LEDS-1 wraps to 0).
  - duty never overflows or underflows.
- PWM compare:
  - pwm_on = (pwm_cnt < duty), unsigned compare.
  - duty=0 gives no on-cycles per period; duty=MAX gives MAX of 2^PWM_BITS cycles on.
- LED register, updated every edge, with one cycle of latency from pwm_cnt/duty/mode:
  - OFF: led=0.
  - BREATHE: every bit = pwm_on.
  - CHASE: led[pos]=pwm_on, all other bits 0.
  - FULL: all bits 1.
- Mode changes:
  - Take effect in led on the edge after mode changes.
  - Leaving OFF resumes the ramp from its frozen state.
- tick held high for N consecutive cycles counts N ticks.

Test Plan:
All scenarios use PWM_BITS=4, STEP_TICKS=2, NUM_LEDS=5 (MAX=15).
1. Reset: hold rst 3 cycles with tick=1 and mode=3 -> led=0, duty=0, dir_down=0, pos=0. With mode=3, led=5'b11111 on the first edge after rst drops.
2. Minimum duty: mode=1, tick=1 for 2 cycles -> duty=1. Then tick=0 for 32 cycles -> led=5'b11111 for exactly 1 cycle per 16, one cycle after pwm_cnt==0.
3. Full ramp: mode=1, tick=1 continuously. After 30 ticks: duty=15, dir_down=0. Tick 32: duty=14, dir_down=1. Tick 60: duty=0. Tick 62: duty=1, dir_down=0, pos=1.
4. Chase wrap: mode=2, tick=1 continuously for 310 ticks (5 full cycles) -> pos runs 1,2,3,4,0. Only led[pos] ever toggles; all other bits stay 0.
5. Freeze and full: in mode=1 at duty=7, switch to mode=0 and pulse tick 10 times -> duty=7 held, led=0. Switch to mode=3 -> led=5'b11111 next edge; the ramp resumes from duty=7.
6. Reset mid-operation: at duty=9, dir_down=1, pos=3, assert rst for 1 cycle with tick=1 -> next edge all outputs are at reset values and step_cnt=0.

Source files
------------

// File: rtl/led_breathe_seq_if.sv
// Bus between the LED breathing sequencer and its controller: step strobe and
// pattern select in, registered LED drive and ramp status out.
interface led_breathe_seq_if #(
    parameter int PWM_BITS = 8,
    parameter int NUM_LEDS = 5
);
    logic                tick;
    logic [1:0]          mode;
    logic [NUM_LEDS-1:0] led;
    logic [PWM_BITS-1:0] duty;
    logic                dir_down;
    logic [2:0]          pos;

    modport master (
        output tick, mode,
        input  led, duty, dir_down, pos
    );

    modport slave (
        input  tick, mode,
        output led, duty, dir_down, pos
    );
endinterface

// File: rtl/led_breathe_seq.sv
// PWM "breathing" LED stage driven by the heartbeat tick strobe: a triangular
// brightness ramp feeds a PWM compare, shown as off, breathe-all, chase or full-on.
module led_breathe_seq #(
    parameter int PWM_BITS   = 8,
    parameter int STEP_TICKS = 4,
    parameter int NUM_LEDS   = 5
) (
    input logic              hwclk,
    input logic              rst,
    led_breathe_seq_if.slave bus
);
    localparam int SW = $clog2(STEP_TICKS + 1);
    localparam logic [SW-1:0]       STEP_LAST = SW'(STEP_TICKS - 1);
    localparam logic [PWM_BITS-1:0] DUTY_MAX  = '1;
    localparam logic [2:0]          POS_LAST  = 3'(NUM_LEDS - 1);

    typedef enum logic {ST_UP, ST_DOWN} ramp_t;
    typedef enum logic [1:0] {MODE_OFF, MODE_BREATHE, MODE_CHASE, MODE_FULL} mode_t;

    logic [PWM_BITS-1:0] r_pwm_cnt;
    logic [SW-1:0]       r_step_cnt;
    logic [PWM_BITS-1:0] r_duty;
    logic [2:0]          r_pos;
    logic [NUM_LEDS-1:0] r_led;
    ramp_t               r_state;

    mode_t               w_mode;
    logic                w_active;
    logic                w_step;
    logic                w_pwm_on;
    ramp_t               w_state_next;
    logic [PWM_BITS-1:0] w_duty_next;
    logic [2:0]          w_pos_next;
    logic [NUM_LEDS-1:0] w_led_next;

    assign w_mode   = mode_t'(bus.mode);
    assign w_active = (w_mode != MODE_OFF);
    assign w_step   = w_active && bus.tick && (r_step_cnt == STEP_LAST);
    assign w_pwm_on = (r_pwm_cnt < r_duty);

    // Ramp turns around at the extremes without dwelling, so duty never wraps.
    always_comb begin
        w_state_next = r_state;
        w_duty_next  = r_duty;
        w_pos_next   = r_pos;
        if (w_step) begin
            case (r_state)
                ST_UP: begin
                    if (r_duty == DUTY_MAX) begin
                        w_duty_next  = DUTY_MAX - 1'b1;
                        w_state_next = ST_DOWN;
                    end else begin
                        w_duty_next = r_duty + 1'b1;
                    end
                end
                ST_DOWN: begin
                    if (r_duty == '0) begin
                        w_duty_next  = PWM_BITS'(1);
                        w_state_next = ST_UP;
                        w_pos_next   = (r_pos == POS_LAST) ? 3'd0 : r_pos + 3'd1;
                    end else begin
                        w_duty_next = r_duty - 1'b1;
                    end
                end
                default: w_state_next = ST_UP;
            endcase
        end
    end

    always_comb begin
        w_led_next = '0;
        case (w_mode)
            MODE_OFF:     w_led_next = '0;
            MODE_BREATHE: w_led_next = {NUM_LEDS{w_pwm_on}};
            MODE_CHASE: begin
                for (int i = 0; i < NUM_LEDS; i++) begin
                    w_led_next[i] = w_pwm_on && (r_pos == 3'(i));
                end
            end
            MODE_FULL:    w_led_next = '1;
            default:      w_led_next = '0;
        endcase
    end

    // PWM counter free-runs in every mode; step count and ramp freeze while OFF.
    always_ff @(posedge hwclk) begin
        if (rst) begin
            r_pwm_cnt  <= '0;
            r_step_cnt <= '0;
            r_duty     <= '0;
            r_pos      <= '0;
            r_led      <= '0;
            r_state    <= ST_UP;
        end else begin
            r_pwm_cnt <= r_pwm_cnt + 1'b1;
            r_led     <= w_led_next;
            if (w_active) begin
                if (bus.tick) begin
                    r_step_cnt <= w_step ? '0 : r_step_cnt + 1'b1;
                end
                r_state <= w_state_next;
                r_duty  <= w_duty_next;
                r_pos   <= w_pos_next;
            end
        end
    end

    assign bus.led      = r_led;
    assign bus.duty     = r_duty;
    assign bus.dir_down = (r_state == ST_DOWN);
    assign bus.pos      = r_pos;
endmodule
